// File: rtl/i2s_serdes.sv
// Bit-level I2S front end: synchronises the codec's BCLK/LRCLK/SDATA into aclk, deserialises
// ADC slots into left/right words and serialises left/right words onto the DAC line.
module i2s_serdes #(
   parameter int D_WIDTH     = 24,
   parameter int SLOT_BITS   = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic               aclk,
   input  logic               aresetn,
   input  logic               i2s_bclk,
   input  logic               i2s_lrclk,
   input  logic               i2s_adc_sdata,
   output logic               i2s_dac_sdata,
   output logic               ws,
   output logic [D_WIDTH-1:0] l_data_recv_codec,
   output logic [D_WIDTH-1:0] r_data_recv_codec,
   input  logic [D_WIDTH-1:0] l_data_tr_to_codec,
   input  logic [D_WIDTH-1:0] r_data_tr_to_codec,
   output logic               frame_err,
   output logic [1:0]         dbg_state
);

   localparam int CW = $clog2(SLOT_BITS + 1);
   localparam int IW = $clog2(D_WIDTH);

   typedef enum logic [1:0] {UNLOCKED = 2'd0, LEFT = 2'd1, RIGHT = 2'd2} state_t;

   state_t state, state_nx;

   logic [SYNC_STAGES-1:0] bclk_sync, lrclk_sync, sdata_sync;
   logic                   bclk_s, lrclk_s, sdata_s, bclk_d;
   logic                   rise, fall, slot_start, locked;
   logic                   lrclk_q, commit_pend;
   logic [CW-1:0]          bit_cnt, cnt_nx;
   logic [D_WIDTH-1:0]     rx_sr, tx_sr;
   logic [IW-1:0]          tx_idx;

   assign bclk_s     = bclk_sync[SYNC_STAGES-1];
   assign lrclk_s    = lrclk_sync[SYNC_STAGES-1];
   assign sdata_s    = sdata_sync[SYNC_STAGES-1];
   assign rise       = bclk_s & ~bclk_d;
   assign fall       = ~bclk_s & bclk_d;
   assign slot_start = rise && (lrclk_s != lrclk_q);
   assign locked     = (state != UNLOCKED);
   assign tx_idx     = IW'(D_WIDTH - 1) - IW'(bit_cnt);
   assign dbg_state  = state;

   always_comb begin
      cnt_nx = bit_cnt;
      if (slot_start)
         cnt_nx = '0;
      else if (bit_cnt != CW'(SLOT_BITS))
         cnt_nx = bit_cnt + 1'b1;
   end

   // Lock only on a left slot start so the first word delivered is always a left word.
   always_comb begin
      state_nx = state;
      if (slot_start) begin
         case (state)
            UNLOCKED: if (!lrclk_s) state_nx = LEFT;
            default:  state_nx = lrclk_s ? RIGHT : LEFT;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         state <= UNLOCKED;
      else
         state <= state_nx;
   end

   // All three pins share one chain depth so data and word select stay aligned with BCLK.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         bclk_sync  <= '0;
         lrclk_sync <= '0;
         sdata_sync <= '0;
         bclk_d     <= 1'b0;
      end else begin
         bclk_sync  <= {bclk_sync[SYNC_STAGES-2:0], i2s_bclk};
         lrclk_sync <= {lrclk_sync[SYNC_STAGES-2:0], i2s_lrclk};
         sdata_sync <= {sdata_sync[SYNC_STAGES-2:0], i2s_adc_sdata};
         bclk_d     <= bclk_s;
      end
   end

   // ws is the word strobe: a left commit drives it high and a right commit low, in the same
   // cycle as the matching data bus, so a consumer may latch a bus on the ws edge.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         lrclk_q           <= 1'b0;
         bit_cnt           <= '0;
         rx_sr             <= '0;
         tx_sr             <= '0;
         commit_pend       <= 1'b0;
         frame_err         <= 1'b0;
         ws                <= 1'b0;
         i2s_dac_sdata     <= 1'b0;
         l_data_recv_codec <= '0;
         r_data_recv_codec <= '0;
      end else begin
         frame_err   <= 1'b0;
         commit_pend <= 1'b0;
         if (rise) begin
            bit_cnt <= cnt_nx;
            if (slot_start)
               lrclk_q <= lrclk_s;
            if (locked && cnt_nx != '0 && cnt_nx <= CW'(D_WIDTH))
               rx_sr <= {rx_sr[D_WIDTH-2:0], sdata_s};
            commit_pend <= locked && (cnt_nx == CW'(D_WIDTH));
            if (slot_start && (locked || !lrclk_s))
               tx_sr <= lrclk_s ? r_data_tr_to_codec : l_data_tr_to_codec;
            // A saturated counter was already reported when it hit SLOT_BITS.
            if (locked && slot_start && bit_cnt != CW'(SLOT_BITS - 1) && bit_cnt != CW'(SLOT_BITS))
               frame_err <= 1'b1;
            if (locked && !slot_start && bit_cnt == CW'(SLOT_BITS - 1))
               frame_err <= 1'b1;
         end
         if (commit_pend) begin
            if (state == LEFT) begin
               l_data_recv_codec <= rx_sr;
               ws                <= 1'b1;
            end else if (state == RIGHT) begin
               r_data_recv_codec <= rx_sr;
               ws                <= 1'b0;
            end
         end
         if (fall)
            i2s_dac_sdata <= (locked && bit_cnt < CW'(D_WIDTH)) ? tx_sr[tx_idx] : 1'b0;
      end
   end

endmodule
